// File: rtl/masked_gf24_div_pkg.sv
// Shared constants and GF(2^2) helpers for the masked GF(2^4) divider.
// Normal bases: GF(2^4) {Z^4, Z} over GF(2^2) {W^2, W}; norm N = W^2.
package masked_gf24_div_pkg;

   localparam logic [3:0] GF24_ONE = 4'b1111;

   localparam int unsigned RndW     = 10;
   localparam int unsigned RndS1Lsb = 0;
   localparam int unsigned RndS1W   = 2;
   localparam int unsigned RndS2Lsb = 2;
   localparam int unsigned RndS2W   = 4;
   localparam int unsigned RndS3Lsb = 6;
   localparam int unsigned RndS3W   = 4;

   localparam int unsigned LfsrW    = 31;
   // x^31 + x^28 + 1: feedback taps at bits 30 and 27
   localparam logic [LfsrW-1:0] LfsrPoly = 31'h4800_0000;
   localparam logic [LfsrW-1:0] LfsrSeed = 31'h5A5A_5A5A;

   function automatic logic [1:0] gf22_mul(input logic [1:0] x, input logic [1:0] y);
      logic e;
      e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
      return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
   endfunction

   function automatic logic [1:0] gf22_sq(input logic [1:0] x);
      return {x[0], x[1]};
   endfunction

   // N * x with N = W^2
   function automatic logic [1:0] gf22_scl_n(input logic [1:0] x);
      return {x[0], x[1] ^ x[0]};
   endfunction

   // N * x^2
   function automatic logic [1:0] gf22_sq_scl(input logic [1:0] x);
      return {x[1], x[1] ^ x[0]};
   endfunction

endpackage

// File: rtl/masked_gf24_div_if.sv
// Handshake and share bus of the masked divider; rnd is absent when INTERNAL_PRNG_EN is defined.
interface masked_gf24_div_if;
   import masked_gf24_div_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [3:0]      a0, a1, b0, b1;
`ifndef INTERNAL_PRNG_EN
   logic [RndW-1:0] rnd;
`endif
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      q0, q1;

`ifdef INTERNAL_PRNG_EN
   modport slave  (input  in_valid, a0, a1, b0, b1, out_ready,
                   output in_ready, out_valid, q0, q1);
   modport master (output in_valid, a0, a1, b0, b1, out_ready,
                   input  in_ready, out_valid, q0, q1);
`else
   modport slave  (input  in_valid, a0, a1, b0, b1, rnd, out_ready,
                   output in_ready, out_valid, q0, q1);
   modport master (output in_valid, a0, a1, b0, b1, rnd, out_ready,
                   input  in_ready, out_valid, q0, q1);
`endif
endinterface

// File: rtl/masked_gf24_div_dom_mul.sv
// Two-share DOM GF(2^2) multiplier; combinational, the instantiating stage registers the result.
module masked_gf22_dom_mul
   import masked_gf24_div_pkg::*;
(
   input  logic [1:0] x0_i,
   input  logic [1:0] x1_i,
   input  logic [1:0] y0_i,
   input  logic [1:0] y1_i,
   input  logic [1:0] r_i,
   output logic [1:0] z0_o,
   output logic [1:0] z1_o
);

   // Cross terms are blinded by r before meeting the inner-domain term.
   assign z0_o = (gf22_mul(x0_i, y1_i) ^ r_i) ^ gf22_mul(x0_i, y0_i);
   assign z1_o = (gf22_mul(x1_i, y0_i) ^ r_i) ^ gf22_mul(x1_i, y1_i);

endmodule

// File: rtl/masked_gf24_div.sv
// Three-stage first-order masked GF(2^4) divider q = a / b (q = 0 for b = 0).
// INTERNAL_PRNG_EN replaces the rnd port with an internal 31-bit LFSR.
module masked_gf24_div
   import masked_gf24_div_pkg::*;
(
   input logic              clk,
   input logic              rst,
   masked_gf24_div_if.slave bus
);

   logic [RndW-1:0] rnd;
   logic v1_q, v2_q, v3_q;
   logic ld1, ld2, ld3;
   logic en1, en2, en3;

   // Ready chain only looks downstream, so in_valid never reaches in_ready.
   assign ld3 = ~v3_q | bus.out_ready;
   assign ld2 = ~v2_q | ld3;
   assign ld1 = ~v1_q | ld2;
   assign en1 = ld1 & bus.in_valid;
   assign en2 = ld2 & v1_q;
   assign en3 = ld3 & v2_q;

   assign bus.in_ready  = ld1;
   assign bus.out_valid = v3_q;

`ifdef INTERNAL_PRNG_EN
   logic [LfsrW-1:0] lfsr_q, lfsr_d;
   assign lfsr_d = {lfsr_q[LfsrW-2:0], ^(lfsr_q & LfsrPoly)};
   assign rnd    = lfsr_q[RndW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LfsrSeed;
      end else if (en1 | en2 | en3) begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign rnd = bus.rnd;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         if (ld1) v1_q <= bus.in_valid;
         if (ld2) v2_q <= v1_q;
         if (ld3) v3_q <= v2_q;
      end
   end

   // Stage 1: d = bh*bl ^ N*(bh^bl)^2
   logic [RndS1W-1:0] r1;
   logic [1:0] s1_p0, s1_p1;
   logic [1:0] s1_d0_d, s1_d1_d, s1_d0_q, s1_d1_q;
   logic [3:0] s1_a0_q, s1_a1_q, s1_b0_q, s1_b1_q;

   assign r1 = rnd[RndS1Lsb +: RndS1W];

   masked_gf22_dom_mul u_s1_mul (
      .x0_i (bus.b0[3:2]),
      .x1_i (bus.b1[3:2]),
      .y0_i (bus.b0[1:0]),
      .y1_i (bus.b1[1:0]),
      .r_i  (r1),
      .z0_o (s1_p0),
      .z1_o (s1_p1)
   );

   assign s1_d0_d = s1_p0 ^ gf22_sq_scl(bus.b0[3:2] ^ bus.b0[1:0]);
   assign s1_d1_d = s1_p1 ^ gf22_sq_scl(bus.b1[3:2] ^ bus.b1[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_d0_q <= '0;
         s1_d1_q <= '0;
         s1_a0_q <= '0;
         s1_a1_q <= '0;
         s1_b0_q <= '0;
         s1_b1_q <= '0;
      end else if (en1) begin
         s1_d0_q <= s1_d0_d;
         s1_d1_q <= s1_d1_d;
         s1_a0_q <= bus.a0;
         s1_a1_q <= bus.a1;
         s1_b0_q <= bus.b0;
         s1_b1_q <= bus.b1;
      end
   end

   // Stage 2: b^-1 = {d^-1 * bl, d^-1 * bh}, d^-1 = d^2
   logic [RndS2W-1:0] r2;
   logic [1:0] s2_dinv0, s2_dinv1;
   logic [1:0] s2_h0, s2_h1, s2_l0, s2_l1;
   logic [3:0] s2_binv0_d, s2_binv1_d, s2_binv0_q, s2_binv1_q;
   logic [3:0] s2_a0_q, s2_a1_q;

   assign r2       = rnd[RndS2Lsb +: RndS2W];
   assign s2_dinv0 = gf22_sq(s1_d0_q);
   assign s2_dinv1 = gf22_sq(s1_d1_q);

   masked_gf22_dom_mul u_s2_mul_h (
      .x0_i (s2_dinv0),
      .x1_i (s2_dinv1),
      .y0_i (s1_b0_q[1:0]),
      .y1_i (s1_b1_q[1:0]),
      .r_i  (r2[1:0]),
      .z0_o (s2_h0),
      .z1_o (s2_h1)
   );

   masked_gf22_dom_mul u_s2_mul_l (
      .x0_i (s2_dinv0),
      .x1_i (s2_dinv1),
      .y0_i (s1_b0_q[3:2]),
      .y1_i (s1_b1_q[3:2]),
      .r_i  (r2[3:2]),
      .z0_o (s2_l0),
      .z1_o (s2_l1)
   );

   assign s2_binv0_d = {s2_h0, s2_l0};
   assign s2_binv1_d = {s2_h1, s2_l1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_binv0_q <= '0;
         s2_binv1_q <= '0;
         s2_a0_q    <= '0;
         s2_a1_q    <= '0;
      end else if (en2) begin
         s2_binv0_q <= s2_binv0_d;
         s2_binv1_q <= s2_binv1_d;
         s2_a0_q    <= s1_a0_q;
         s2_a1_q    <= s1_a1_q;
      end
   end

   // Stage 3: q = a * b^-1 in GF(2^4) from three GF(2^2) gadgets
   logic [RndS3W-1:0] r3;
   logic [1:0] s3_hh0, s3_hh1, s3_ll0, s3_ll1, s3_ee0, s3_ee1;
   logic [3:0] q0_d, q1_d, q0_q, q1_q;

   assign r3 = rnd[RndS3Lsb +: RndS3W];

   masked_gf22_dom_mul u_s3_mul_hh (
      .x0_i (s2_a0_q[3:2]),
      .x1_i (s2_a1_q[3:2]),
      .y0_i (s2_binv0_q[3:2]),
      .y1_i (s2_binv1_q[3:2]),
      .r_i  (r3[1:0]),
      .z0_o (s3_hh0),
      .z1_o (s3_hh1)
   );

   masked_gf22_dom_mul u_s3_mul_ll (
      .x0_i (s2_a0_q[1:0]),
      .x1_i (s2_a1_q[1:0]),
      .y0_i (s2_binv0_q[1:0]),
      .y1_i (s2_binv1_q[1:0]),
      .r_i  (r3[3:2]),
      .z0_o (s3_ll0),
      .z1_o (s3_ll1)
   );

   // Mixed-term gadget draws its mask from both slice halves.
   masked_gf22_dom_mul u_s3_mul_ee (
      .x0_i (s2_a0_q[3:2] ^ s2_a0_q[1:0]),
      .x1_i (s2_a1_q[3:2] ^ s2_a1_q[1:0]),
      .y0_i (s2_binv0_q[3:2] ^ s2_binv0_q[1:0]),
      .y1_i (s2_binv1_q[3:2] ^ s2_binv1_q[1:0]),
      .r_i  (r3[1:0] ^ r3[3:2]),
      .z0_o (s3_ee0),
      .z1_o (s3_ee1)
   );

   assign q0_d = {s3_hh0 ^ gf22_scl_n(s3_ee0), s3_ll0 ^ gf22_scl_n(s3_ee0)};
   assign q1_d = {s3_hh1 ^ gf22_scl_n(s3_ee1), s3_ll1 ^ gf22_scl_n(s3_ee1)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q0_q <= '0;
         q1_q <= '0;
      end else if (en3) begin
         q0_q <= q0_d;
         q1_q <= q1_d;
      end
   end

   assign bus.q0 = q0_q;
   assign bus.q1 = q1_q;

endmodule

// File: tb/tb_masked_gf24_div.sv
// Directed self-checking bench for masked_gf24_div with an in-order result scoreboard.
module tb_masked_gf24_div;
   import masked_gf24_div_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   masked_gf24_div_if bus ();

   masked_gf24_div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pops   = 0;
   int accs   = 0;
   int pop_cyc = 0;
   logic [3:0] exp_next;
   logic [3:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference GF(2^2) product written directly from W-arithmetic.
   function automatic logic [1:0] m_gf4_mul(input logic [1:0] x, input logic [1:0] y);
      logic hi, lo;
      hi = (x[0] & y[0]) ^ (x[1] & y[0]) ^ (x[0] & y[1]);
      lo = (x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]);
      return {hi, lo};
   endfunction

   function automatic logic [3:0] m_gf16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] hh, ll, e, ne;
      hh = m_gf4_mul(a[3:2], b[3:2]);
      ll = m_gf4_mul(a[1:0], b[1:0]);
      e  = m_gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
      ne = m_gf4_mul(2'b10, e);
      return {hh ^ ne, ll ^ ne};
   endfunction

   function automatic logic [3:0] m_div(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] inv;
      inv = 4'h0;
      for (int c = 1; c < 16; c++) begin
         if (m_gf16_mul(b, 4'(c)) == GF24_ONE) inv = 4'(c);
      end
      return m_gf16_mul(a, inv);
   endfunction

   task automatic step();
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
         exp_q.push_back(exp_next);
         accs++;
      end
      if (bus.out_valid && bus.out_ready) begin
         pops++;
         pop_cyc = cyc;
         check_eq("pop_has_expect", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check_eq("result", 32'(bus.q0 ^ bus.q1), 32'(exp_q.pop_front()));
      end
      cyc++;
      @(posedge clk);
      #1;
`ifndef INTERNAL_PRNG_EN
      bus.rnd = 10'($urandom);
`endif
   endtask

   task automatic set_sh(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] b0,
                         input logic [3:0] b1, input logic [3:0] exp);
      bus.a0 = a0;
      bus.a1 = a1;
      bus.b0 = b0;
      bus.b1 = b1;
      exp_next = exp;
      bus.in_valid = 1'b1;
   endtask

   task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp);
      logic [3:0] ma, mb;
      ma = 4'($urandom);
      mb = 4'($urandom);
      set_sh(ma, a ^ ma, mb, b ^ mb, exp);
   endtask

   task automatic drain(input int n);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < n && exp_q.size() > 0; i++) step();
      check_eq("drained", 32'(exp_q.size()), 32'd0);
   endtask

   logic [3:0] va[6] = '{4'b1111, 4'b0110, 4'b1010, 4'b0000, 4'b0110, 4'b0101};
   logic [3:0] vb[6] = '{4'b0110, 4'b1111, 4'b0000, 4'b0101, 4'b0110, 4'b1111};
   logic [3:0] vq[6] = '{4'b0111, 4'b0110, 4'b0000, 4'b0000, 4'b1111, 4'b0101};

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int p0, first, send_cyc;
      logic [3:0] s0, s1;
      logic have_snap;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
      exp_next = '0;
`ifndef INTERNAL_PRNG_EN
      bus.rnd = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_q0", 32'(bus.q0), 32'd0);
      check_eq("rst_q1", 32'(bus.q1), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single op: one/one, latency
      set_in(GF24_ONE, GF24_ONE, GF24_ONE);
      send_cyc = cyc;
      p0 = pops;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10 && pops == p0; i++) step();
      check_eq("latency", 32'(pop_cyc - send_cyc), 32'd3);

      // Zero divisor with equal shares
      set_sh(4'b1001, 4'b0011, 4'b0110, 4'b0110, 4'b0000);
      step();
      for (int i = 0; i < 6; i++) begin
         set_in(va[i], vb[i], vq[i]);
         step();
      end
      drain(20);

      // 16 back-to-back a = b = 0110
      p0 = pops;
      first = -1;
      for (int i = 0; i < 16; i++) begin
         set_in(4'b0110, 4'b0110, GF24_ONE);
         check_eq("b2b_in_ready", 32'(bus.in_ready), 32'd1);
         step();
         if (first < 0 && pops > p0) first = pop_cyc;
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
         step();
         if (first < 0 && pops > p0) first = pop_cyc;
      end
      check_eq("b2b_count", 32'(pops - p0), 32'd16);
      check_eq("b2b_span", 32'(pop_cyc - first), 32'd15);

      // Full-pipe stall
      p0 = accs;
      bus.out_ready = 1'b0;
      have_snap = 1'b0;
      s0 = '0;
      s1 = '0;
      for (int i = 0; i < 10; i++) begin
         set_in(4'b0101, 4'b1111, 4'b0101);
         step();
         if (bus.out_valid) begin
            if (have_snap) begin
               check_eq("stall_q0", 32'(bus.q0), 32'(s0));
               check_eq("stall_q1", 32'(bus.q1), 32'(s1));
            end else begin
               s0 = bus.q0;
               s1 = bus.q1;
               have_snap = 1'b1;
            end
         end
      end
      check_eq("stall_accepts", 32'(accs - p0), 32'd3);
      check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
      p0 = pops;
      drain(10);
      check_eq("stall_pops", 32'(pops - p0), 32'd3);

      // All 256 pairs, random back-pressure
      p0 = pops;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] idx;
         int a_before;
         idx = 8'(i);
         set_in(idx[7:4], idx[3:0], m_div(idx[7:4], idx[3:0]));
         a_before = accs;
         for (int t = 0; t < 50 && accs == a_before; t++) begin
            bus.out_ready = 1'($urandom);
            step();
         end
         check_eq("sweep_accept", 32'(accs - a_before), 32'd1);
      end
      drain(30);
      check_eq("sweep_pops", 32'(pops - p0), 32'd256);

      // Reset with two ops in flight
      bus.out_ready = 1'b1;
      set_in(4'b0011, 4'b0111, m_div(4'b0011, 4'b0111));
      step();
      set_in(4'b1100, 4'b1011, m_div(4'b1100, 4'b1011));
      step();
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("midrst_q0", 32'(bus.q0), 32'd0);
      check_eq("midrst_q1", 32'(bus.q1), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      p0 = pops;
      for (int i = 0; i < 6; i++) step();
      check_eq("midrst_no_stale", 32'(pops - p0), 32'd0);
      check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
